// File: rtl/ring_seq_pkg.sv
// Shared types and constants for the ring sequencer.
// Used by ring_sequencer and ring_seq_lap_cnt.
package ring_seq_pkg;

    typedef enum logic [1:0] {
        RING   = 2'd0,
        BOUNCE = 2'd1,
        HOLD   = 2'd2,
        RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int unsigned LAP_MAX = 255;

endpackage

// File: rtl/ring_seq_lap_cnt.sv
// Saturating 8-bit lap counter for ring_sequencer.
// Only instantiated when RING_SEQ_LAP_CNT_EN is defined.
module ring_seq_lap_cnt
    import ring_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] laps
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            laps <= 8'd0;
        end else if (inc && (laps != 8'(LAP_MAX))) begin
            laps <= laps + 8'd1;
        end
    end

endmodule

// File: rtl/ring_sequencer.sv
// One-hot ring/bounce/hold sequencer with binary position, wrap and done flags.
// Optional saturating lap counter output enabled by macro RING_SEQ_LAP_CNT_EN.
module ring_sequencer
    import ring_seq_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int RESET_POS = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     dir,
    input  logic [1:0]               mode,
    input  logic                     load,
    input  logic [$clog2(WIDTH)-1:0] load_pos,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     wrap,
    output logic                     done,
    output logic                     cur_dir
`ifdef RING_SEQ_LAP_CNT_EN
    ,
    output logic [7:0]               laps
`endif
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] PMAX = PW'(WIDTH - 1);

    mode_e         mode_s;
    dir_e          dir_s;
    dir_e          dir_q;
    dir_e          dir_next;
    logic [PW-1:0] pos_next;
    logic [PW-1:0] pos_up;
    logic [PW-1:0] pos_dn;
    logic          at_top;
    logic          at_bot;
    logic          wrap_next;
    logic          done_next;

    assign mode_s  = mode_e'(mode);
    assign dir_s   = dir_e'(dir);
    assign cur_dir = dir_q;
    assign at_top  = (pos == PMAX);
    assign at_bot  = (pos == '0);
    assign pos_up  = pos + PW'(1);
    assign pos_dn  = pos - PW'(1);

    // NOTE: every output of this block is defaulted first so no path leaves a latch.
    always_comb begin
        pos_next  = pos;
        dir_next  = dir_q;
        done_next = done;
        wrap_next = 1'b0;
        if (load) begin
            pos_next  = (load_pos > PMAX) ? PMAX : load_pos;
            dir_next  = dir_s;
            done_next = 1'b0;
        end else begin
            if (mode_s != HOLD) done_next = 1'b0;
            if (en) begin
                unique case (mode_s)
                    BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (at_top) begin
                                pos_next  = PMAX - PW'(1);
                                dir_next  = DIR_DOWN;
                                wrap_next = 1'b1;
                            end else begin
                                pos_next = pos_up;
                            end
                        end else begin
                            if (at_bot) begin
                                pos_next  = PW'(1);
                                dir_next  = DIR_UP;
                                wrap_next = 1'b1;
                            end else begin
                                pos_next = pos_dn;
                            end
                        end
                        // With two positions every step is a reversal.
                        if (WIDTH == 2) wrap_next = 1'b1;
                    end
                    HOLD: begin
                        dir_next = dir_s;
                        if (dir_s == DIR_UP) begin
                            if (at_top) begin
                                done_next = 1'b1;
                            end else begin
                                pos_next  = pos_up;
                                done_next = (pos_up == PMAX);
                                wrap_next = (pos_up == PMAX);
                            end
                        end else begin
                            if (at_bot) begin
                                done_next = 1'b1;
                            end else begin
                                pos_next  = pos_dn;
                                done_next = (pos_dn == '0);
                                wrap_next = (pos_dn == '0);
                            end
                        end
                    end
                    default: begin
                        dir_next = dir_s;
                        if (dir_s == DIR_UP) begin
                            pos_next  = at_top ? '0 : pos_up;
                            wrap_next = at_top;
                        end else begin
                            pos_next  = at_bot ? PMAX : pos_dn;
                            wrap_next = at_bot;
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= WIDTH'(1) << RESET_POS;
            pos   <= PW'(RESET_POS);
            wrap  <= 1'b0;
            done  <= 1'b0;
            dir_q <= DIR_UP;
        end else begin
            q     <= WIDTH'(1) << pos_next;
            pos   <= pos_next;
            wrap  <= wrap_next;
            done  <= done_next;
            dir_q <= dir_next;
        end
    end

`ifdef RING_SEQ_LAP_CNT_EN
    ring_seq_lap_cnt u_lap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .inc   (wrap_next),
        .laps  (laps)
    );
`endif

endmodule

// File: tb/tb_ring_sequencer.sv
// Self-checking bench for ring_sequencer: directed scenarios plus random stimulus
// against a behavioural model, on WIDTH=4, 3 and 2 instances.
module tb_ring_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       load = 1'b0;
    logic [1:0] load_pos4 = 2'd0;
    logic [1:0] load_pos3 = 2'd0;
    logic [0:0] load_pos2 = 1'b0;

    logic [3:0] q4;
    logic [1:0] pos4;
    logic       wrap4, done4, cd4;
    logic [2:0] q3;
    logic [1:0] pos3;
    logic       wrap3, done3, cd3;
    logic [1:0] q2;
    logic [0:0] pos2;
    logic       wrap2, done2, cd2;
`ifdef RING_SEQ_LAP_CNT_EN
    logic [7:0] laps4, laps3, laps2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_sequencer #(.WIDTH(4), .RESET_POS(0)) dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_pos(load_pos4), .q(q4), .pos(pos4), .wrap(wrap4), .done(done4), .cur_dir(cd4)
`ifdef RING_SEQ_LAP_CNT_EN
        , .laps(laps4)
`endif
    );

    ring_sequencer #(.WIDTH(3), .RESET_POS(1)) dut3 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_pos(load_pos3), .q(q3), .pos(pos3), .wrap(wrap3), .done(done3), .cur_dir(cd3)
`ifdef RING_SEQ_LAP_CNT_EN
        , .laps(laps3)
`endif
    );

    ring_sequencer #(.WIDTH(2), .RESET_POS(1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_pos(load_pos2), .q(q2), .pos(pos2), .wrap(wrap2), .done(done2), .cur_dir(cd2)
`ifdef RING_SEQ_LAP_CNT_EN
        , .laps(laps2)
`endif
    );

    typedef struct {
        int p;
        bit cd;
        bit done;
        bit wrap;
        int laps;
    } mstate_t;

    // Behavioural model: position as an integer walking a ring, a zig-zag or a clamped line.
    function automatic mstate_t model_next(input mstate_t s, input int w, input int rp,
                                           input bit rst, input bit ld, input int lp,
                                           input bit e, input bit d, input int m);
        mstate_t n;
        int tgt;
        n = s;
        n.wrap = 1'b0;
        if (rst) begin
            n.p = rp; n.cd = 1'b0; n.done = 1'b0; n.laps = 0;
            return n;
        end
        if (ld) begin
            n.p = (lp > w - 1) ? w - 1 : lp; n.cd = d; n.done = 1'b0; n.laps = 0;
            return n;
        end
        if (m != 2) n.done = 1'b0;
        if (e) begin
            if (m == 1) begin
                if (!s.cd && s.p == w - 1) begin
                    n.p = w - 2; n.cd = 1'b1; n.wrap = 1'b1;
                end else if (s.cd && s.p == 0) begin
                    n.p = 1; n.cd = 1'b0; n.wrap = 1'b1;
                end else begin
                    n.p = s.cd ? s.p - 1 : s.p + 1;
                end
                if (w == 2) n.wrap = 1'b1;
            end else if (m == 2) begin
                n.cd = d;
                tgt = d ? 0 : w - 1;
                if (s.p == tgt) begin
                    n.done = 1'b1;
                end else begin
                    n.p = d ? s.p - 1 : s.p + 1;
                    n.done = (n.p == tgt);
                    n.wrap = (n.p == tgt);
                end
            end else begin
                n.cd = d;
                n.p = (s.p + (d ? w - 1 : 1)) % w;
                n.wrap = d ? (s.p == 0) : (s.p == w - 1);
            end
        end
        if (n.wrap && n.laps < 255) n.laps = n.laps + 1;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load = 1'b0; en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        mode = 2'd0; dir = 1'b0;
        do_reset();
        checks++;
        if (q4 !== 4'b0001 || pos4 !== 2'd0 || wrap4 !== 1'b0 || done4 !== 1'b0 || cd4 !== 1'b0) begin
            errors++;
            $display("FAIL reset4: got q=%b pos=%0d wrap=%b done=%b cd=%b, expected q=0001 pos=0 wrap=0 done=0 cd=0",
                     q4, pos4, wrap4, done4, cd4);
        end
        checks++;
        if (q3 !== 3'b010 || pos3 !== 2'd1) begin
            errors++;
            $display("FAIL reset3: got q=%b pos=%0d, expected q=010 pos=1", q3, pos3);
        end
        checks++;
        if (q2 !== 2'b10 || pos2 !== 1'b1) begin
            errors++;
            $display("FAIL reset2: got q=%b pos=%0d, expected q=10 pos=1", q2, pos2);
        end
    endtask

    task automatic test_ring_up();
        logic [3:0] exp_q [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic       exp_w [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        mode = 2'd0; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (q4 !== exp_q[i] || wrap4 !== exp_w[i]) begin
                errors++;
                $display("FAIL ring_up[%0d]: got q=%b wrap=%b, expected q=%b wrap=%b",
                         i, q4, wrap4, exp_q[i], exp_w[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_ring_down();
        logic [3:0] exp_q [3] = '{4'b1000, 4'b0100, 4'b0010};
        logic       exp_w [3] = '{1'b1, 1'b0, 1'b0};
        do_reset();
        mode = 2'd3; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q4 !== exp_q[i] || wrap4 !== exp_w[i] || cd4 !== 1'b1) begin
                errors++;
                $display("FAIL ring_down[%0d]: got q=%b wrap=%b cd=%b, expected q=%b wrap=%b cd=1",
                         i, q4, wrap4, cd4, exp_q[i], exp_w[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_bounce();
        logic [3:0] exp_q [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                  4'b0010, 4'b0001, 4'b0010, 4'b0100};
        logic       exp_w [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] e2;
        do_reset();
        mode = 2'd1; dir = 1'b1; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            e2 = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (q4 !== exp_q[i] || wrap4 !== exp_w[i]) begin
                errors++;
                $display("FAIL bounce[%0d]: got q=%b wrap=%b, expected q=%b wrap=%b",
                         i, q4, wrap4, exp_q[i], exp_w[i]);
            end
            checks++;
            if (q2 !== e2 || wrap2 !== 1'b1) begin
                errors++;
                $display("FAIL bounce_w2[%0d]: got q=%b wrap=%b, expected q=%b wrap=1", i, q2, wrap2, e2);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (q4 !== 4'b0100 || wrap4 !== 1'b0) begin
            errors++;
            $display("FAIL bounce_idle: got q=%b wrap=%b, expected q=0100 wrap=0", q4, wrap4);
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_q [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
        logic       exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       exp_w [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        mode = 2'd2; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (q4 !== exp_q[i] || done4 !== exp_d[i] || wrap4 !== exp_w[i]) begin
                errors++;
                $display("FAIL hold[%0d]: got q=%b done=%b wrap=%b, expected q=%b done=%b wrap=%b",
                         i, q4, done4, wrap4, exp_q[i], exp_d[i], exp_w[i]);
            end
        end
        dir = 1'b1;
        tick();
        checks++;
        if (q4 !== 4'b0100 || done4 !== 1'b0 || cd4 !== 1'b1) begin
            errors++;
            $display("FAIL hold_away: got q=%b done=%b cd=%b, expected q=0100 done=0 cd=1", q4, done4, cd4);
        end
        dir = 1'b0;
        tick();
        mode = 2'd0; en = 1'b0;
        tick();
        checks++;
        if (q4 !== 4'b1000 || done4 !== 1'b0 || wrap4 !== 1'b0) begin
            errors++;
            $display("FAIL hold_leave: got q=%b done=%b wrap=%b, expected q=1000 done=0 wrap=0", q4, done4, wrap4);
        end
    endtask

    task automatic test_load();
        do_reset();
        mode = 2'd0; dir = 1'b1; en = 1'b1; load = 1'b1;
        load_pos4 = 2'd2; load_pos3 = 2'd3; load_pos2 = 1'b0;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (q4 !== 4'b0100 || pos4 !== 2'd2 || wrap4 !== 1'b0 || cd4 !== 1'b1) begin
            errors++;
            $display("FAIL load4: got q=%b pos=%0d wrap=%b cd=%b, expected q=0100 pos=2 wrap=0 cd=1",
                     q4, pos4, wrap4, cd4);
        end
        checks++;
        if (q3 !== 3'b100 || pos3 !== 2'd2) begin
            errors++;
            $display("FAIL load3_clamp: got q=%b pos=%0d, expected q=100 pos=2", q3, pos3);
        end
    endtask

    task automatic test_reset_override();
        mode = 2'd0; dir = 1'b1;
        reset = 1'b1; load = 1'b1; en = 1'b1; load_pos4 = 2'd3;
        tick();
        reset = 1'b0; load = 1'b0; en = 1'b0;
        checks++;
        if (q4 !== 4'b0001 || cd4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_vs_load: got q=%b cd=%b, expected q=0001 cd=0", q4, cd4);
        end
        mode = 2'd1; en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (q4 !== 4'b0100 || cd4 !== 1'b1) begin
            errors++;
            $display("FAIL bounce_down_state: got q=%b cd=%b, expected q=0100 cd=1", q4, cd4);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; en = 1'b0;
        checks++;
        if (q4 !== 4'b0001 || cd4 !== 1'b0 || wrap4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_bounce: got q=%b cd=%b wrap=%b, expected q=0001 cd=0 wrap=0", q4, cd4, wrap4);
        end
    endtask

    task automatic test_random();
        mstate_t m4, m3, m2;
        do_reset();
        m4 = '{p: 0, cd: 1'b0, done: 1'b0, wrap: 1'b0, laps: 0};
        m3 = '{p: 1, cd: 1'b0, done: 1'b0, wrap: 1'b0, laps: 0};
        m2 = '{p: 1, cd: 1'b0, done: 1'b0, wrap: 1'b0, laps: 0};
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            load      = ($urandom_range(0, 11) == 0);
            en        = ($urandom_range(0, 3) != 0);
            dir       = ($urandom_range(0, 4) == 0) ? ~dir : dir;
            mode      = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : mode;
            load_pos4 = 2'($urandom_range(0, 3));
            load_pos3 = 2'($urandom_range(0, 3));
            load_pos2 = 1'($urandom_range(0, 1));
            m4 = model_next(m4, 4, 0, reset, load, int'(load_pos4), en, dir, int'(mode));
            m3 = model_next(m3, 3, 1, reset, load, int'(load_pos3), en, dir, int'(mode));
            m2 = model_next(m2, 2, 1, reset, load, int'(load_pos2), en, dir, int'(mode));
            tick();
            checks++;
            if (q4 !== 4'(1 << m4.p) || pos4 !== 2'(m4.p) || wrap4 !== m4.wrap
                || done4 !== m4.done || cd4 !== m4.cd) begin
                errors++;
                $display("FAIL rand4[%0d]: got q=%b wrap=%b done=%b cd=%b, expected q=%b wrap=%b done=%b cd=%b",
                         i, q4, wrap4, done4, cd4, 4'(1 << m4.p), m4.wrap, m4.done, m4.cd);
            end
            checks++;
            if (q3 !== 3'(1 << m3.p) || pos3 !== 2'(m3.p) || wrap3 !== m3.wrap
                || done3 !== m3.done || cd3 !== m3.cd) begin
                errors++;
                $display("FAIL rand3[%0d]: got q=%b wrap=%b done=%b cd=%b, expected q=%b wrap=%b done=%b cd=%b",
                         i, q3, wrap3, done3, cd3, 3'(1 << m3.p), m3.wrap, m3.done, m3.cd);
            end
            checks++;
            if (q2 !== 2'(1 << m2.p) || pos2 !== 1'(m2.p) || wrap2 !== m2.wrap
                || done2 !== m2.done || cd2 !== m2.cd) begin
                errors++;
                $display("FAIL rand2[%0d]: got q=%b wrap=%b done=%b cd=%b, expected q=%b wrap=%b done=%b cd=%b",
                         i, q2, wrap2, done2, cd2, 2'(1 << m2.p), m2.wrap, m2.done, m2.cd);
            end
`ifdef RING_SEQ_LAP_CNT_EN
            checks++;
            if (laps4 !== 8'(m4.laps) || laps3 !== 8'(m3.laps) || laps2 !== 8'(m2.laps)) begin
                errors++;
                $display("FAIL rand_laps[%0d]: got %0d/%0d/%0d, expected %0d/%0d/%0d",
                         i, laps4, laps3, laps2, m4.laps, m3.laps, m2.laps);
            end
`endif
        end
        reset = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_laps();
`ifdef RING_SEQ_LAP_CNT_EN
        do_reset();
        checks++;
        if (laps4 !== 8'd0) begin
            errors++;
            $display("FAIL laps_reset: got %0d, expected 0", laps4);
        end
        mode = 2'd0; dir = 1'b0; en = 1'b1;
        for (int i = 0; i < 1200; i++) tick();
        checks++;
        if (laps4 !== 8'd255) begin
            errors++;
            $display("FAIL laps_sat: got %0d, expected 255", laps4);
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (laps4 !== 8'd255) begin
            errors++;
            $display("FAIL laps_hold: got %0d, expected 255", laps4);
        end
        load = 1'b1; load_pos4 = 2'd1;
        tick();
        load = 1'b0; en = 1'b0;
        checks++;
        if (laps4 !== 8'd0) begin
            errors++;
            $display("FAIL laps_load: got %0d, expected 0", laps4);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_ring_up();
        test_ring_down();
        test_bounce();
        test_hold();
        test_load();
        test_reset_override();
        test_random();
        test_laps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
